parallel_hypervisor_cpu_debug_scan_master: RTL and testbench

System-clock-domain initiator for the Nios II virtual-JTAG debug slave. It accepts a debug command (IR value plus a 38-bit data register image) and generates the virtual-JTAG pin sequence the debug slave's TCK logic consumes: `tck`, `tdi`, `ir_in`, `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_e1dr` and `jtag_state_rti`. It captures the slave's `tdo` and `ir_out` and returns them as a response. It replaces the tied-off virtual-JTAG stubs in simulation and bench environments, and serves as an on-chip debug driver.

---
 rtl/parallel_hypervisor_cpu_debug_scan_master_if.sv | 20 ++
 rtl/parallel_hypervisor_cpu_debug_scan_master.sv | 122 ++++++++++++
 tb/tb_parallel_hypervisor_cpu_debug_scan_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/parallel_hypervisor_cpu_debug_scan_master_if.sv
// rtl/parallel_hypervisor_cpu_debug_scan_master_if.sv - command/response handshake bundle for the debug scan master
interface parallel_hypervisor_cpu_debug_scan_master_if #(parameter int DATA_W = 38);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_ir;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [1:0]        rsp_ir_out;

    modport master (
        output cmd_valid, cmd_ir, cmd_data,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );

    modport slave (
        input  cmd_valid, cmd_ir, cmd_data,
        output cmd_ready, rsp_valid, rsp_data, rsp_ir_out
    );
endinterface

// File: rtl/parallel_hypervisor_cpu_debug_scan_master.sv
// rtl/parallel_hypervisor_cpu_debug_scan_master.sv - virtual-JTAG pin sequencer driving a Nios II debug slave
module parallel_hypervisor_cpu_debug_scan_master #(
    parameter int DATA_W     = 38,
    parameter int TCK_HALF   = 2,
    parameter int RTI_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    parallel_hypervisor_cpu_debug_scan_master_if.slave bus,
    output logic       tck,
    output logic       tdi,
    input  logic       tdo,
    output logic [1:0] ir_in,
    input  logic [1:0] ir_out,
    output logic       vs_uir,
    output logic       vs_cdr,
    output logic       vs_sdr,
    output logic       vs_e1dr,
    output logic       jtag_state_rti
);
    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int HC_W  = $clog2(TCK_HALF + 1);
    localparam int RTI_W = $clog2(RTI_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, E1DR, RTI} state_t;

    state_t            state;
    logic [HC_W-1:0]   hc;
    logic [CNT_W-1:0]  bit_cnt;
    logic [RTI_W-1:0]  rti_cnt;
    logic [DATA_W-1:0] shreg;

    assign bus.cmd_ready = (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            hc             <= '0;
            bit_cnt        <= '0;
            rti_cnt        <= '0;
            shreg          <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= 2'b00;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_e1dr        <= 1'b0;
            jtag_state_rti <= 1'b0;
            bus.rsp_valid  <= 1'b0;
            bus.rsp_data   <= '0;
            bus.rsp_ir_out <= 2'b00;
        end else begin
            bus.rsp_valid <= 1'b0;
            if (state == IDLE) begin
                tck <= 1'b0;
                hc  <= '0;
                if (bus.cmd_valid) begin
                    ir_in   <= bus.cmd_ir;
                    shreg   <= bus.cmd_data;
                    tdi     <= bus.cmd_data[0];
                    bit_cnt <= '0;
                    rti_cnt <= '0;
                    state   <= UIR;
                    vs_uir  <= 1'b1;
                end
            end else if (hc != HC_W'(TCK_HALF - 1)) begin
                hc <= hc + HC_W'(1);
            end else begin
                hc  <= '0;
                tck <= ~tck;
                if (!tck) begin
                    // Rise: the slave samples tdi here, so only capture happens on this edge.
                    if (state == CDR)
                        bus.rsp_ir_out <= ir_out;
                    if (state == SDR) begin
                        shreg   <= {tdo, shreg[DATA_W-1:1]};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end else begin
                    // Fall: all state, strobe and tdi changes land here, clear of the next rise.
                    tdi <= shreg[0];
                    case (state)
                        UIR: begin
                            state  <= CDR;
                            vs_uir <= 1'b0;
                            vs_cdr <= 1'b1;
                        end
                        CDR: begin
                            state  <= SDR;
                            vs_cdr <= 1'b0;
                            vs_sdr <= 1'b1;
                        end
                        SDR: begin
                            if (bit_cnt == CNT_W'(DATA_W)) begin
                                state   <= E1DR;
                                vs_sdr  <= 1'b0;
                                vs_e1dr <= 1'b1;
                            end
                        end
                        E1DR: begin
                            state          <= RTI;
                            vs_e1dr        <= 1'b0;
                            jtag_state_rti <= 1'b1;
                        end
                        RTI: begin
                            if (rti_cnt == RTI_W'(RTI_CYCLES - 1)) begin
                                state          <= IDLE;
                                jtag_state_rti <= 1'b0;
                                bus.rsp_valid  <= 1'b1;
                                bus.rsp_data   <= shreg;
                            end else begin
                                rti_cnt <= rti_cnt + RTI_W'(1);
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_parallel_hypervisor_cpu_debug_scan_master.sv
// tb/tb_parallel_hypervisor_cpu_debug_scan_master.sv - scoreboard bench with behavioural debug-slave models
module tb_parallel_hypervisor_cpu_debug_scan_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Instance A: default parameters
    parallel_hypervisor_cpu_debug_scan_master_if #(.DATA_W(38)) ia ();
    logic tck_a, tdi_a, tdo_a, vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a;
    logic [1:0] ir_in_a;
    logic [1:0] ir_out_a = 2'b10;
    logic [37:0] sr_a = 38'h2A_5A5A_5A5A;
    assign tdo_a = sr_a[0];
    always @(posedge tck_a) if (vs_sdr_a) sr_a <= {tdi_a, sr_a[37:1]};

    parallel_hypervisor_cpu_debug_scan_master #(.DATA_W(38), .TCK_HALF(2), .RTI_CYCLES(2)) dut_a (
        .clk(clk), .reset(reset), .bus(ia), .tck(tck_a), .tdi(tdi_a), .tdo(tdo_a),
        .ir_in(ir_in_a), .ir_out(ir_out_a), .vs_uir(vs_uir_a), .vs_cdr(vs_cdr_a),
        .vs_sdr(vs_sdr_a), .vs_e1dr(vs_e1dr_a), .jtag_state_rti(rti_a)
    );

    // Instance B: fastest tck, single RTI period
    parallel_hypervisor_cpu_debug_scan_master_if #(.DATA_W(38)) ib ();
    logic tck_b, tdi_b, tdo_b, vs_uir_b, vs_cdr_b, vs_sdr_b, vs_e1dr_b, rti_b;
    logic [1:0] ir_in_b;
    logic [1:0] ir_out_b = 2'b01;
    logic [37:0] sr_b = 38'h3F_0000_0001;
    assign tdo_b = sr_b[0];
    always @(posedge tck_b) if (vs_sdr_b) sr_b <= {tdi_b, sr_b[37:1]};

    parallel_hypervisor_cpu_debug_scan_master #(.DATA_W(38), .TCK_HALF(1), .RTI_CYCLES(1)) dut_b (
        .clk(clk), .reset(reset), .bus(ib), .tck(tck_b), .tdi(tdi_b), .tdo(tdo_b),
        .ir_in(ir_in_b), .ir_out(ir_out_b), .vs_uir(vs_uir_b), .vs_cdr(vs_cdr_b),
        .vs_sdr(vs_sdr_b), .vs_e1dr(vs_e1dr_b), .jtag_state_rti(rti_b)
    );

    typedef struct {
        logic [37:0] data;
        logic [1:0]  ir;
        int          acc;
    } exp_t;
    exp_t sbq[$];

    logic [1:0] cur_ir = 2'b00;
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_e1dr = 0, n_rti = 0;
    int onehot_viol = 0, rise_viol = 0, ir_viol = 0, rsp_seen = 0;
    int a_last_rise = 0, a_period = 0, b_last_rise = 0, b_period = 0;
    logic prev_tck_a = 1'b0, prev_tck_b = 1'b0, prev_tdi_a = 1'b0;
    logic [4:0] prev_str_a = 5'b0;

    always @(negedge clk) begin
        logic [4:0] str;
        exp_t e;
        str = {vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a};
        if ($countones(str) > 1) onehot_viol++;
        if (!ia.cmd_ready && ir_in_a !== cur_ir) ir_viol++;
        if (!prev_tck_a && tck_a) begin
            if (str !== prev_str_a || tdi_a !== prev_tdi_a) rise_viol++;
            if (vs_uir_a) begin
                n_uir = 1; n_cdr = 0; n_sdr = 0; n_e1dr = 0; n_rti = 0;
            end
            if (vs_cdr_a)  n_cdr++;
            if (vs_sdr_a)  n_sdr++;
            if (vs_e1dr_a) n_e1dr++;
            if (rti_a)     n_rti++;
            a_period = cyc - a_last_rise;
            a_last_rise = cyc;
        end
        if (!prev_tck_b && tck_b) begin
            b_period = cyc - b_last_rise;
            b_last_rise = cyc;
        end
        if (reset) sbq.delete();
        if (ia.rsp_valid) begin
            rsp_seen++;
            check("rsp_expected", 64'(sbq.size() != 0), 64'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                check("rsp_data", 64'(ia.rsp_data), 64'(e.data));
                check("rsp_ir_out", 64'(ia.rsp_ir_out), 64'(e.ir));
                check("latency", 64'(cyc - e.acc), 64'd172);
                check("uir_rises", 64'(n_uir), 64'd1);
                check("cdr_rises", 64'(n_cdr), 64'd1);
                check("sdr_rises", 64'(n_sdr), 64'd38);
                check("e1dr_rises", 64'(n_e1dr), 64'd1);
                check("rti_rises", 64'(n_rti), 64'd2);
            end
        end
        prev_tck_a = tck_a;
        prev_tck_b = tck_b;
        prev_tdi_a = tdi_a;
        prev_str_a = str;
    end

    task automatic send(input logic [1:0] ir, input logic [37:0] d, input bit hold, output bit with_rsp);
        int n = 0;
        exp_t e;
        ia.cmd_valid = 1'b1;
        ia.cmd_ir    = ir;
        ia.cmd_data  = d;
        while (!ia.cmd_ready && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("accepted", 64'(ia.cmd_ready), 64'd1);
        with_rsp = ia.rsp_valid;
        e.data = sr_a;
        e.ir   = ir_out_a;
        e.acc  = cyc + 1;
        sbq.push_back(e);
        cur_ir = ir;
        @(negedge clk);
        if (!hold) ia.cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sbq.size() != 0 || !ia.cmd_ready) && n < 600) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("scan_done", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        bit wr;
        int n;
        int snap;
        int acc;
        logic [37:0] exp_b;
        ia.cmd_valid = 1'b0; ia.cmd_ir = 2'b00; ia.cmd_data = '0;
        ib.cmd_valid = 1'b0; ib.cmd_ir = 2'b00; ib.cmd_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_cmd_ready", 64'(ia.cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(ia.rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(ia.rsp_data), 64'd0);
        check("rst_rsp_ir_out", 64'(ia.rsp_ir_out), 64'd0);
        check("rst_tck", 64'(tck_a), 64'd0);
        check("rst_tdi", 64'(tdi_a), 64'd0);
        check("rst_ir_in", 64'(ir_in_a), 64'd0);
        check("rst_strobes", 64'({vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a}), 64'd0);

        // single scan against the slave model
        @(negedge clk);
        send(2'b01, 38'h15_1234_5678, 1'b0, wr);
        wait_done();
        check("slave_sr", 64'(sr_a), 64'(38'h15_1234_5678));
        check("tck_period_a", 64'(a_period), 64'd4);

        // back-to-back with cmd_valid held
        ir_out_a = 2'b11;
        send(2'b10, 38'h00_CAFE_F00D, 1'b1, wr);
        send(2'b11, 38'h3F_0F0F_1234, 1'b0, wr);
        check("b2b_accept_in_rsp_cycle", 64'(wr), 64'd1);
        wait_done();
        check("slave_sr_b2b", 64'(sr_a), 64'(38'h3F_0F0F_1234));

        // reset after the 20th SDR rise
        send(2'b10, 38'h00_FFFF_0000, 1'b0, wr);
        n = 0;
        while (!(vs_sdr_a && n_sdr >= 20) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("reached_sdr20", 64'(n_sdr), 64'd20);
        reset = 1'b1;
        #1;
        check("abort_tck", 64'(tck_a), 64'd0);
        check("abort_strobes", 64'({vs_uir_a, vs_cdr_a, vs_sdr_a, vs_e1dr_a, rti_a}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        snap = rsp_seen;
        repeat (200) @(negedge clk);
        check("no_rsp_after_abort", 64'(rsp_seen - snap), 64'd0);
        send(2'b01, 38'h2B_DEAD_BEEF, 1'b0, wr);
        wait_done();
        check("slave_sr_after_abort", 64'(sr_a), 64'(38'h2B_DEAD_BEEF));

        // fast instance: TCK_HALF=1, RTI_CYCLES=1
        ib.cmd_valid = 1'b1;
        ib.cmd_ir    = 2'b11;
        ib.cmd_data  = 38'h0A_BCDE_F012;
        n = 0;
        while (!ib.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("b_accepted", 64'(ib.cmd_ready), 64'd1);
        acc = cyc + 1;
        exp_b = sr_b;
        @(negedge clk);
        ib.cmd_valid = 1'b0;
        n = 0;
        while (!ib.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("b_rsp_valid", 64'(ib.rsp_valid), 64'd1);
        check("b_latency", 64'(cyc - acc), 64'd84);
        check("b_rsp_data", 64'(ib.rsp_data), 64'(exp_b));
        check("b_rsp_ir_out", 64'(ib.rsp_ir_out), 64'd1);
        check("b_slave_sr", 64'(sr_b), 64'(38'h0A_BCDE_F012));
        check("b_ir_in", 64'(ir_in_b), 64'd3);
        check("tck_period_b", 64'(b_period), 64'd2);

        check("strobe_onehot", 64'(onehot_viol), 64'd0);
        check("change_on_rise", 64'(rise_viol), 64'd0);
        check("ir_in_hold", 64'(ir_viol), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
